// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA frame fetch path.
package vga_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait,
      StFlush
   } fetch_state_e;

   localparam int unsigned DefWidth  = 640;
   localparam int unsigned DefHeight = 480;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; head is read combinationally.
module sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [DW-1:0]                wr_data,
   input  logic                         rd_en,
   output logic [DW-1:0]                rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CountMax = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_wr, do_rd;

   always_comb begin
      do_wr   = wr_en & (count_q != CountMax);
      do_rd   = rd_en & (count_q != '0);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_wr) wptr_d = wptr_q + PW'(1);
         if (do_rd) rptr_d = rptr_q + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !clr) mem_q[wptr_q] <= wr_data;
   end

   always_comb begin
      rd_data = mem_q[rptr_q];
      count   = count_q;
      empty   = (count_q == '0);
   end

endmodule

// File: rtl/vga_fetch.sv
// Frame fetcher: reads one frame per vtrigger from memory and streams pixels into the VGA FIFO,
// limiting outstanding reads so returned data always has a buffer slot.
module vga_fetch
   import vga_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned HEIGHT = DefHeight,
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vtrigger,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       fifo_data,
   output logic              fifo_write,
   input  logic              fifo_full,
   output logic              busy,
   output logic              frame_late
);

   localparam int unsigned PIXELS = WIDTH * HEIGHT;
   localparam int unsigned IW     = $clog2(PIXELS + 1);
   localparam int unsigned OW     = $clog2(DEPTH + 1);
   localparam logic [IW-1:0] IssuedMax  = IW'(PIXELS);
   localparam logic [IW-1:0] IssuedLast = IW'(PIXELS - 1);
   localparam logic [OW:0]   CreditMax  = (OW + 1)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IW-1:0]     issued_q, issued_d;
   logic [OW-1:0]     outst_q, outst_d;
   logic              frame_late_q, frame_late_d;

   logic [OW-1:0] buf_count;
   logic          buf_empty;
   rgb565_t       buf_head;
   logic          buf_push, buf_clr;
   logic          ack_fire, rd_accept, final_ack, pending_next;
   logic [OW:0]   credit_used, buf_count_next;

   sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (16)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (buf_clr),
      .wr_en   (buf_push),
      .wr_data (mem_rdata),
      .rd_en   (fifo_write),
      .rd_data (buf_head),
      .count   (buf_count),
      .empty   (buf_empty)
   );

   // Returns with nothing outstanding belong to a read lost across reset and are ignored.
   always_comb begin
      ack_fire  = mem_req & mem_ack;
      rd_accept = mem_rvalid & (outst_q != '0);
      buf_push  = rd_accept & (state_q != StFlush);
      final_ack = ack_fire & (issued_q == IssuedLast);
      case ({ack_fire, rd_accept})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase
      buf_count_next = {1'b0, buf_count} + (OW + 1)'(buf_push) - (OW + 1)'(fifo_write);
      pending_next   = (outst_d != '0) || (buf_count_next != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         base_q       <= '0;
         issued_q     <= '0;
         outst_q      <= '0;
         frame_late_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         issued_q     <= issued_d;
         outst_q      <= outst_d;
         frame_late_q <= frame_late_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      issued_d     = issued_q;
      frame_late_d = 1'b0;
      if (ack_fire) issued_d = issued_q + IW'(1);
      unique case (state_q)
         StIdle: begin
            if (vtrigger) begin
               base_d   = fb_base;
               issued_d = '0;
               state_d  = StFetch;
            end
         end
         StFetch: begin
            if (vtrigger) begin
               base_d = fb_base;
               if (!final_ack) begin
                  frame_late_d = 1'b1;
                  state_d      = StFlush;
               end else if (pending_next) begin
                  state_d = StFlush;
               end else begin
                  issued_d = '0;
               end
            end else if (final_ack) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (vtrigger) begin
               base_d = fb_base;
               if (pending_next) begin
                  frame_late_d = 1'b1;
                  state_d      = StFlush;
               end else begin
                  issued_d = '0;
                  state_d  = StFetch;
               end
            end else if (outst_q == '0 && buf_empty) begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            if (vtrigger) base_d = fb_base;
            if (outst_q == '0) begin
               issued_d = '0;
               state_d  = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = (state_q != StIdle);
      buf_clr     = (state_q == StFlush);
      credit_used = {1'b0, outst_q} + {1'b0, buf_count};
      mem_req     = (state_q == StFetch) && (issued_q < IssuedMax) && (credit_used < CreditMax);
      mem_addr    = base_q + ADDR_W'(issued_q);
      fifo_write  = ~buf_empty & ~fifo_full & (state_q != StFlush);
      fifo_data   = buf_empty ? 16'h0000 : buf_head;
      frame_late  = frame_late_q;
   end

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch with a latency-modelling memory and a pixel/address scoreboard.
module tb_vga_fetch;

   localparam int unsigned W   = 4;
   localparam int unsigned H   = 2;
   localparam int unsigned AW  = 24;
   localparam int unsigned D   = 4;
   localparam int unsigned PIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vtrigger;
   logic [AW-1:0] fb_base;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic          mem_rvalid;
   logic [15:0]   mem_rdata;
   logic [15:0]   fifo_data;
   logic          fifo_write;
   logic          fifo_full;
   logic          busy;
   logic          frame_late;

   vga_fetch #(
      .WIDTH  (W),
      .HEIGHT (H),
      .ADDR_W (AW),
      .DEPTH  (D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vtrigger   (vtrigger),
      .fb_base    (fb_base),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .fifo_data  (fifo_data),
      .fifo_write (fifo_write),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .frame_late (frame_late)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      int unsigned   due;
   } rd_t;

   rd_t           rd_q[$];
   logic [AW-1:0] exp_addr[$];
   logic [15:0]   exp_pix[$];

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int          acc_cnt = 0;
   int          wr_cnt = 0;
   int          late_cnt = 0;
   int          max_inflight = 0;
   bit          ack_rand = 1'b0;
   bit          full_rand = 1'b0;
   bit          full_hold = 1'b0;
   int unsigned lat_min = 2;
   int unsigned lat_max = 2;

   function automatic logic [15:0] pix_of(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hC3A5 ^ {a[23:16], 8'h00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic trigger(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      for (int i = 0; i < int'(PIX); i++) begin
         a = base + AW'(i);
         exp_addr.push_back(a);
         exp_pix.push_back(pix_of(a));
      end
      fb_base  = base;
      vtrigger = 1'b1;
      tick();
      vtrigger = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n = 0;
      while (busy !== 1'b0 && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_acc(input string tag, input int target, input int max_cyc);
      int n = 0;
      while (acc_cnt < target && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_acc"}, 32'(acc_cnt), 32'(target));
   endtask

   task automatic wait_wr(input string tag, input int target, input int max_cyc);
      int n = 0;
      while (wr_cnt < target && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_wr"}, 32'(wr_cnt >= target), 32'd1);
   endtask

   task automatic clear_counts();
      acc_cnt      = 0;
      wr_cnt       = 0;
      late_cnt     = 0;
      max_inflight = 0;
   endtask

   // Memory and VGA FIFO environment: drives on negedge, samples 1 time unit later.
   initial begin
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      fifo_full  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         mem_ack   = ack_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         fifo_full = full_hold | (full_rand && ($urandom_range(0, 3) == 0));
         if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pix_of(rd_q[0].addr);
            void'(rd_q.pop_front());
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'hDEAD;
         end
         #1;
         if (mem_req && mem_ack) begin
            acc_cnt++;
            rd_q.push_back('{addr: mem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
            chk("req_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) chk("addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
         end
         if (fifo_write) begin
            wr_cnt++;
            chk("write_expected", 32'(exp_pix.size() != 0), 32'd1);
            if (exp_pix.size() != 0) chk("pixel", 32'(fifo_data), 32'(exp_pix.pop_front()));
         end
         if (frame_late) late_cnt++;
         if (acc_cnt - wr_cnt > max_inflight) max_inflight = acc_cnt - wr_cnt;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      vtrigger = 1'b0;
      fb_base  = '0;
      repeat (3) tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_fifo_write", 32'(fifo_write), 32'd0);
      chk("rst_fifo_data", 32'(fifo_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_late", 32'(frame_late), 32'd0);
      rst_n = 1'b1;
      tick();

      // Plain frame, fixed 2-cycle latency
      clear_counts();
      trigger(24'h000100);
      chk("t1_first_req", 32'(mem_req), 32'd1);
      chk("t1_first_addr", 32'(mem_addr), 32'h100);
      wait_idle("t1", 500);
      chk("t1_writes", 32'(wr_cnt), 32'(PIX));
      chk("t1_pix_left", 32'(exp_pix.size()), 32'd0);
      chk("t1_late", 32'(late_cnt), 32'd0);

      // Back-pressure mid-frame: requests stall with exactly D pixels in flight
      clear_counts();
      trigger(24'h000100);
      wait_wr("t2_pre", 2, 500);
      full_hold = 1'b1;
      repeat (20) tick();
      chk("t2_inflight", 32'(acc_cnt - wr_cnt), 32'(D));
      chk("t2_req_stall", 32'(mem_req), 32'd0);
      full_hold = 1'b0;
      wait_idle("t2", 500);
      chk("t2_writes", 32'(wr_cnt), 32'(PIX));
      chk("t2_pix_left", 32'(exp_pix.size()), 32'd0);

      // Random ack, random 1..12 latency, random back-pressure
      ack_rand  = 1'b1;
      full_rand = 1'b1;
      lat_min   = 1;
      lat_max   = 12;
      for (int f = 0; f < 3; f++) begin
         clear_counts();
         trigger(AW'($urandom));
         wait_idle("t3", 3000);
         chk("t3_writes", 32'(wr_cnt), 32'(PIX));
         chk("t3_credit", 32'(max_inflight <= int'(D)), 32'd1);
         chk("t3_pix_left", 32'(exp_pix.size()), 32'd0);
      end
      ack_rand  = 1'b0;
      full_rand = 1'b0;
      lat_min   = 2;
      lat_max   = 2;
      repeat (5) tick();

      // Abort after 3 acks; stale returns must be discarded
      clear_counts();
      full_hold = 1'b1;
      trigger(24'h000100);
      wait_acc("t4", 3, 100);
      exp_addr.delete();
      exp_pix.delete();
      trigger(24'h000200);
      chk("t4_late_pulse", 32'(frame_late), 32'd1);
      full_hold = 1'b0;
      tick();
      chk("t4_late_single", 32'(frame_late), 32'd0);
      wait_idle("t4", 500);
      chk("t4_writes", 32'(wr_cnt), 32'(PIX));
      chk("t4_late_cnt", 32'(late_cnt), 32'd1);
      chk("t4_pix_left", 32'(exp_pix.size()), 32'd0);

      // Address wrap at 2^24
      clear_counts();
      trigger(24'hFFFFFE);
      chk("t5_first_addr", 32'(mem_addr), 32'hFFFFFE);
      wait_idle("t5", 500);
      chk("t5_writes", 32'(wr_cnt), 32'(PIX));
      chk("t5_addr_left", 32'(exp_addr.size()), 32'd0);

      // Reset with reads in flight; late returns must not reach the FIFO
      clear_counts();
      lat_min = 10;
      lat_max = 10;
      trigger(24'h000300);
      wait_acc("t6", 3, 100);
      rst_n = 1'b0;
      #1;
      chk("t6_mem_req", 32'(mem_req), 32'd0);
      chk("t6_mem_addr", 32'(mem_addr), 32'd0);
      chk("t6_fifo_write", 32'(fifo_write), 32'd0);
      chk("t6_fifo_data", 32'(fifo_data), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_frame_late", 32'(frame_late), 32'd0);
      exp_addr.delete();
      exp_pix.delete();
      wr_cnt = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (25) tick();
      chk("t6_no_writes", 32'(wr_cnt), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);

      // Recovery frame after reset
      clear_counts();
      lat_min = 2;
      lat_max = 2;
      trigger(24'h000400);
      wait_idle("t7", 500);
      chk("t7_writes", 32'(wr_cnt), 32'(PIX));
      chk("t7_pix_left", 32'(exp_pix.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
